cv32e40p_apu_wb_buffer: RTL and testbench
=========================================

// Module: cv32e40p_apu_wb_buffer
// PURPOSE
//  Result buffer between the APU response channel and the LSU/WB register-file write port.
//  Replaces the drop/contention path: an APU result that collides with an LSU writeback is
//  parked here and drained in order when the port is free. It also supplies a read-dependency
//  flag so the ID stage stalls on registers whose APU result is still parked. It sits
//  downstream of the execute stage, next to the WB port mux.
// PARAMETERS
//  DEPTH       2   buffered entries (>=1, power of 2)
//  ADDR_WIDTH  6   register-file write address width (bit 5 = FP regfile)
//  DATA_WIDTH 32   result width
//  FLAG_WIDTH  5   APU status flags (fflags) width
// PORTS
//  clk           in   1              clock
//  rst_n         in   1              asynchronous active-low reset
//  apu_rvalid_i  in   1              APU result valid (single-cycle pulse, no backpressure)
//  apu_waddr_i   in   ADDR_WIDTH     destination of the APU result
//  apu_result_i  in   DATA_WIDTH     APU result data
//  apu_flags_i   in   FLAG_WIDTH     APU status flags
//  lsu_we_i      in   1              LSU owns the WB write port this cycle
//  rd_addr_i     in   3xADDR_WIDTH   ID-stage source operand addresses
//  rd_valid_i    in   3              source operand address valid
//  wb_we_o       out  1              APU write to the WB port this cycle
//  wb_waddr_o    out  ADDR_WIDTH     write address
//  wb_wdata_o    out  DATA_WIDTH     write data
//  fflags_we_o   out  1              flag update strobe, coincident with wb_we_o
//  fflags_o      out  FLAG_WIDTH     flags of the entry being written
//  full_o        out  1              count==DEPTH; the APU dispatcher must withhold apu_req
//  empty_o       out  1              count==0
//  read_dep_o    out  1              a valid rd_addr matches a parked entry
//  overflow_o    out  1              sticky error: push while full without pop
// BEHAVIOUR
//  - Reset: count=0, rd/wr pointers=0, overflow_o=0; all outputs 0 except empty_o=1.
//  - Bypass (0-cycle latency): if apu_rvalid_i & empty & !lsu_we_i, write the inputs straight
//    to wb_*_o and fflags_*_o in the same cycle. Nothing is stored.
//  - Push: if apu_rvalid_i and no bypass, store {waddr,result,flags} at wr_ptr; wr_ptr++.
//  - Pop: if !empty & !lsu_we_i, drive the head entry on wb_*_o; rd_ptr++. The head always
//    wins over a new result, so the new result is pushed and strict arrival order is kept
//    (WAW-safe).
//  - Simultaneous push+pop: count unchanged. This is legal even when full, because the pop
//    frees the slot first.
//  - Push while full with no pop: the entry is dropped, overflow_o is set until reset, and an
//    SVA error fires.
//  - Pointers are log2(DEPTH) bits with natural wrap. Count is log2(DEPTH)+1 bits.
//  - lsu_we_i=1 forces wb_we_o=0 and fflags_we_o=0. The LSU always has priority and the
//    buffer only waits.
//  - read_dep_o is combinational: OR over valid parked entries and valid rd ports of
//    (entry.waddr==rd_addr). The same-cycle bypass does not count, because the register file
//    writes through.
//  - full_o and empty_o are registered-count decodes (no combinational path from inputs).
//  - Reset mid-drain discards all parked entries. No partial write is emitted.
//  - No flush input: APU results are architecturally committed and are never squashed.
// STRUCTURE
//  - cv32e40p_pkg: typedef struct packed {logic[5:0] waddr; logic[31:0] data;
//    logic[4:0] flags;} apu_wb_entry_t; localparam APU_WB_DEPTH=2.
//  - No sub-module. Storage is an inline circular array of apu_wb_entry_t with pointer/count
//    FFs. One always_comb for bypass/pop muxing, one always_ff for state.
//  - The APU dispatcher gates apu_req_o with ~full_o. The WB port mux ORs wb_we_o behind
//    regfile_we_lsu.
// TESTING
//  1. Free port: rvalid, waddr=5, result=0xDEADBEEF, flags=0x01 -> same cycle wb_we_o=1,
//     waddr=5, wdata=0xDEADBEEF, fflags_we_o=1; empty_o stays 1.
//  2. Collision: rvalid with lsu_we_i=1 (waddr=7, 0x11) -> wb_we_o=0, empty_o=0.
//     Next cycle lsu_we_i=0 -> write waddr=7, 0x11; empty_o=1.
//  3. Ordering: hold lsu_we_i=1 and push waddr=3/0xA then waddr=3/0xB (full_o=1). Release
//     -> 0xA then 0xB on consecutive cycles. Final reg3=0xB.
//  4. Full with push+pop: full, lsu_we_i=0, rvalid waddr=9 -> head popped, 9 stored,
//     full_o stays 1, overflow_o=0.
//  5. Overflow: full, lsu_we_i=1, rvalid -> overflow_o=1 and remains 1 until rst_n.
//  6. Dependency and reset: parked waddr=0x21; rd_addr[1]=0x21 valid -> read_dep_o=1;
//     rd_valid[1]=0 -> read_dep_o=0. Assert rst_n=0 mid-drain -> empty_o=1, wb_we_o=0
//     immediately.

Source files
------------

// File: rtl/cv32e40p_apu_wb_buffer_pkg.sv
// Shared types and sizing for the APU writeback result buffer.
package cv32e40p_apu_wb_buffer_pkg;

    localparam int unsigned APU_WB_DEPTH  = 2;
    localparam int unsigned APU_WB_ADDR_W = 6;
    localparam int unsigned APU_WB_DATA_W = 32;
    localparam int unsigned APU_WB_FLAG_W = 5;

    // One parked APU result: destination, data and fflags.
    typedef struct packed {
        logic [5:0]  waddr;
        logic [31:0] data;
        logic [4:0]  flags;
    } apu_wb_entry_t;

endpackage

// File: rtl/cv32e40p_apu_wb_buffer.sv
// Parks APU results that collide with an LSU writeback and drains them in arrival
// order when the port is free; flags ID-stage reads of still-parked destinations.
module cv32e40p_apu_wb_buffer
    import cv32e40p_apu_wb_buffer_pkg::*;
#(
    parameter int unsigned DEPTH         = APU_WB_DEPTH,
    parameter int unsigned ADDR_WIDTH    = APU_WB_ADDR_W,
    parameter int unsigned DATA_WIDTH    = APU_WB_DATA_W,
    parameter int unsigned FLAG_WIDTH    = APU_WB_FLAG_W,
    parameter bit          OVF_ASSERT_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       apu_rvalid_i,
    input  logic [ADDR_WIDTH-1:0]      apu_waddr_i,
    input  logic [DATA_WIDTH-1:0]      apu_result_i,
    input  logic [FLAG_WIDTH-1:0]      apu_flags_i,
    input  logic                       lsu_we_i,
    input  logic [2:0][ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [2:0]                 rd_valid_i,
    output logic                       wb_we_o,
    output logic [ADDR_WIDTH-1:0]      wb_waddr_o,
    output logic [DATA_WIDTH-1:0]      wb_wdata_o,
    output logic                       fflags_we_o,
    output logic [FLAG_WIDTH-1:0]      fflags_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       read_dep_o,
    output logic                       overflow_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    apu_wb_entry_t    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic          w_empty;
    logic          w_full;
    logic          w_bypass;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_store;
    apu_wb_entry_t w_head;
    apu_wb_entry_t w_new;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_bypass = apu_rvalid_i & w_empty & ~lsu_we_i;
    assign w_pop    = ~w_empty & ~lsu_we_i;
    assign w_push   = apu_rvalid_i & ~w_bypass;
    // A push while full is only legal when the head leaves in the same cycle.
    assign w_drop   = w_push & w_full & ~w_pop;
    assign w_store  = w_push & ~w_drop;

    assign w_head = r_mem[r_rd_ptr];
    assign w_new  = '{waddr: apu_waddr_i, data: apu_result_i, flags: apu_flags_i};

    assign full_o     = w_full;
    assign empty_o    = w_empty;
    assign overflow_o = r_overflow;

    // Write-port mux: bypass when nothing is parked, otherwise the head drains first.
    always_comb begin
        wb_we_o     = 1'b0;
        wb_waddr_o  = '0;
        wb_wdata_o  = '0;
        fflags_we_o = 1'b0;
        fflags_o    = '0;
        read_dep_o  = 1'b0;
        if (w_bypass) begin
            wb_we_o     = 1'b1;
            wb_waddr_o  = apu_waddr_i;
            wb_wdata_o  = apu_result_i;
            fflags_we_o = 1'b1;
            fflags_o    = apu_flags_i;
        end else if (w_pop) begin
            wb_we_o     = 1'b1;
            wb_waddr_o  = w_head.waddr;
            wb_wdata_o  = w_head.data;
            fflags_we_o = 1'b1;
            fflags_o    = w_head.flags;
        end
        // An entry is live when its distance from the read pointer is below the count.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            for (int unsigned p = 0; p < 3; p++) begin
                if ((CNT_W'(PTR_W'(PTR_W'(i) - r_rd_ptr)) < r_count) && rd_valid_i[p]
                    && (r_mem[i].waddr == rd_addr_i[p])) begin
                    read_dep_o = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_store) begin
                r_mem[r_wr_ptr] <= w_new;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    a_no_drop: assert property (@(posedge clk) disable iff (!rst_n) !(OVF_ASSERT_EN && w_drop))
        else $error("apu_wb_buffer: APU result dropped while full");

endmodule

// File: tb/tb_cv32e40p_apu_wb_buffer.sv
// Directed scoreboard bench for the APU writeback buffer.
module tb_cv32e40p_apu_wb_buffer;

    typedef struct packed {
        logic [5:0]  waddr;
        logic [31:0] data;
        logic [4:0]  flags;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            apu_rvalid_i;
    logic [5:0]      apu_waddr_i;
    logic [31:0]     apu_result_i;
    logic [4:0]      apu_flags_i;
    logic            lsu_we_i;
    logic [2:0][5:0] rd_addr_i;
    logic [2:0]      rd_valid_i;
    logic            wb_we_o;
    logic [5:0]      wb_waddr_o;
    logic [31:0]     wb_wdata_o;
    logic            fflags_we_o;
    logic [4:0]      fflags_o;
    logic            full_o;
    logic            empty_o;
    logic            read_dep_o;
    logic            overflow_o;

    int          total = 0;
    int          bad   = 0;
    exp_t        sb[$];
    logic [31:0] rf [64];

    cv32e40p_apu_wb_buffer #(.OVF_ASSERT_EN(1'b0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .apu_rvalid_i (apu_rvalid_i),
        .apu_waddr_i  (apu_waddr_i),
        .apu_result_i (apu_result_i),
        .apu_flags_i  (apu_flags_i),
        .lsu_we_i     (lsu_we_i),
        .rd_addr_i    (rd_addr_i),
        .rd_valid_i   (rd_valid_i),
        .wb_we_o      (wb_we_o),
        .wb_waddr_o   (wb_waddr_o),
        .wb_wdata_o   (wb_wdata_o),
        .fflags_we_o  (fflags_we_o),
        .fflags_o     (fflags_o),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .read_dep_o   (read_dep_o),
        .overflow_o   (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [5:0] wa, input logic [31:0] d,
                         input logic [4:0] f, input logic lsu);
        apu_rvalid_i = rv;
        apu_waddr_i  = wa;
        apu_result_i = d;
        apu_flags_i  = f;
        lsu_we_i     = lsu;
    endtask

    task automatic expect_wr(input logic [5:0] wa, input logic [31:0] d, input logic [4:0] f);
        exp_t e;
        e.waddr = wa;
        e.data  = d;
        e.flags = f;
        sb.push_back(e);
    endtask

    // Monitor: every write-port strobe must match the next expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && wb_we_o) begin
                rf[wb_waddr_o] = wb_wdata_o;
                if (lsu_we_i) begin
                    chk("write_during_lsu", 32'(wb_we_o), 32'd0);
                end
                if (sb.size() == 0) begin
                    chk("unexpected_write_addr", 32'(wb_waddr_o), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("wb_waddr", 32'(wb_waddr_o), 32'(e.waddr));
                    chk("wb_wdata", wb_wdata_o, e.data);
                    chk("fflags", 32'(fflags_o), 32'(e.flags));
                    chk("fflags_we", 32'(fflags_we_o), 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
        rd_addr_i  = '0;
        rd_valid_i = '0;
        #12;
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_we", 32'(wb_we_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        chk("rst_dep", 32'(read_dep_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Bypass on a free port.
        cyc();
        drive(1'b1, 6'd5, 32'hDEADBEEF, 5'h01, 1'b0);
        expect_wr(6'd5, 32'hDEADBEEF, 5'h01);
        @(negedge clk);
        chk("t1_we", 32'(wb_we_o), 32'd1);
        cyc();
        drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
        @(negedge clk);
        chk("t1_empty", 32'(empty_o), 32'd1);

        // Collision with LSU, drained next cycle.
        cyc();
        drive(1'b1, 6'd7, 32'h11, 5'h02, 1'b1);
        expect_wr(6'd7, 32'h11, 5'h02);
        @(negedge clk);
        chk("t2_we_blocked", 32'(wb_we_o), 32'd0);
        cyc();
        drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
        @(negedge clk);
        chk("t2_not_empty", 32'(empty_o), 32'd0);
        cyc();
        @(negedge clk);
        chk("t2_empty", 32'(empty_o), 32'd1);
        chk("t2_idle_we", 32'(wb_we_o), 32'd0);

        // WAW ordering to the same register.
        cyc();
        drive(1'b1, 6'd3, 32'hA, 5'h00, 1'b1);
        expect_wr(6'd3, 32'hA, 5'h00);
        cyc();
        drive(1'b1, 6'd3, 32'hB, 5'h00, 1'b1);
        expect_wr(6'd3, 32'hB, 5'h00);
        cyc();
        drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b1);
        @(negedge clk);
        chk("t3_full", 32'(full_o), 32'd1);
        cyc();
        drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
        cyc();
        cyc();
        @(negedge clk);
        chk("t3_empty", 32'(empty_o), 32'd1);
        chk("t3_reg3", rf[3], 32'hB);

        // Full buffer with simultaneous push and pop.
        cyc();
        drive(1'b1, 6'h10, 32'h1, 5'h03, 1'b1);
        expect_wr(6'h10, 32'h1, 5'h03);
        cyc();
        drive(1'b1, 6'h11, 32'h2, 5'h04, 1'b1);
        expect_wr(6'h11, 32'h2, 5'h04);
        cyc();
        drive(1'b1, 6'd9, 32'h9, 5'h05, 1'b0);
        expect_wr(6'd9, 32'h9, 5'h05);
        @(negedge clk);
        chk("t4_ovf", 32'(overflow_o), 32'd0);
        cyc();
        drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b1);
        @(negedge clk);
        chk("t4_full", 32'(full_o), 32'd1);
        chk("t4_ovf2", 32'(overflow_o), 32'd0);

        // Overflow: push while full and LSU holds the port; entry is lost.
        cyc();
        drive(1'b1, 6'h2A, 32'hBAD, 5'h1F, 1'b1);
        cyc();
        drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b1);
        @(negedge clk);
        chk("t5_ovf", 32'(overflow_o), 32'd1);
        cyc();
        drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
        cyc();
        cyc();
        @(negedge clk);
        chk("t5_empty", 32'(empty_o), 32'd1);
        chk("t5_ovf_sticky", 32'(overflow_o), 32'd1);

        // Read dependency on parked entries, then reset while draining.
        cyc();
        drive(1'b1, 6'h21, 32'h55, 5'h06, 1'b1);
        expect_wr(6'h21, 32'h55, 5'h06);
        cyc();
        drive(1'b1, 6'h22, 32'h66, 5'h07, 1'b1);
        expect_wr(6'h22, 32'h66, 5'h07);
        cyc();
        drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b1);
        rd_addr_i[0] = 6'h00;
        rd_addr_i[1] = 6'h21;
        rd_addr_i[2] = 6'h05;
        rd_valid_i   = 3'b010;
        @(negedge clk);
        chk("t6_dep", 32'(read_dep_o), 32'd1);
        rd_valid_i = 3'b101;
        #1;
        chk("t6_dep_invalid", 32'(read_dep_o), 32'd0);
        rd_addr_i[2] = 6'h22;
        #1;
        chk("t6_dep_port2", 32'(read_dep_o), 32'd1);
        cyc();
        drive(1'b0, 6'd0, 32'd0, 5'd0, 1'b0);
        rd_valid_i = 3'b000;
        cyc();
        sb.delete();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_empty", 32'(empty_o), 32'd1);
        chk("t6_rst_we", 32'(wb_we_o), 32'd0);
        chk("t6_rst_ovf", 32'(overflow_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        chk("end_pending", 32'(sb.size()), 32'd0);
        chk("end_empty", 32'(empty_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
